// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
// Purpose: state enum, datapath/counter widths and an operand magnitude
//          helper shared by div_step, div32_seq and div32_seq_if.
// Ports:   none (package).
package div_pkg;

  localparam int DW    = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude of x when signed mode is enabled, otherwise x unchanged.
  // The most negative value maps to itself, which is also its correct
  // unsigned magnitude.
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] x, input logic en);
    return (en && x[DW-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div32_seq_if.sv
// rtl/div32_seq_if.sv - operand/result handshake bundle for div32_seq
// Purpose: groups the request (in_*, a, b, sgn) and response (out_*, q, r,
//          dz, V) channels.
// Ports:   master drives in_valid/a/b/sgn/out_ready and observes the rest;
//          slave (the divider) is the mirror image.
interface div32_seq_if;
  import div_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          sgn;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q;
  logic [DW-1:0] r;
  logic          dz;
  logic          V;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, q, r, dz, V
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, q, r, dz, V
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
// Purpose: compare the shifted partial remainder with the divisor and
//          subtract when it fits.
// Ports:   prem     in  33  shifted partial remainder {rem, next dividend bit}
//          dvs      in  32  divisor magnitude
//          rem_next out 32  remainder after the step
//          qbit     out 1   quotient bit produced by the step
module div_step
  import div_pkg::*;
(
  input  logic [DW:0]   prem,
  input  logic [DW-1:0] dvs,
  output logic [DW-1:0] rem_next,
  output logic          qbit
);

  // prem < 2*dvs always holds, so when the subtraction happens the result
  // is below dvs and the low DW bits of the difference are exact.
  always_comb begin
    qbit     = (prem >= {1'b0, dvs});
    rem_next = qbit ? (prem[DW-1:0] - dvs) : prem[DW-1:0];
  end

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - 32-bit sequential signed/unsigned restoring divider
// Purpose: one quotient bit per clock after an accept; divide-by-zero
//          answers immediately; results held until the consumer accepts.
// Ports:   clk    in  clock, rising edge
//          rst_n  in  asynchronous active-low reset
//          bus    slave modport of div32_seq_if (operands in, results out)
module div32_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  div32_seq_if.slave    bus
);

  state_t         state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]  rem;      // partial remainder
  logic [DW-1:0]  quo;      // dividend bits shifting out / quotient bits in
  logic [DW-1:0]  dvs;      // divisor magnitude
  logic           neg_q;    // operand signs differ in signed mode
  logic           neg_r;    // dividend negative in signed mode
  logic           ovf;      // most-negative / -1 in signed mode
  logic [DW-1:0]  q_r, r_r;
  logic           dz_r, v_r;

  logic [DW-1:0]  rem_next;
  logic           qbit;
  logic [DW-1:0]  quo_next;
  logic           accept;
  logic           last_step;

  div_step u_step (
    .prem     ({rem, quo[DW-1]}),
    .dvs      (dvs),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign quo_next  = {quo[DW-2:0], qbit};
  assign accept    = bus.in_valid && (state == IDLE);
  assign last_step = (cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (bus.b == '0) ? DONE : BUSY;
      BUSY: if (last_step) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf   <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
      v_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= mag(bus.a, bus.sgn);
            dvs   <= mag(bus.b, bus.sgn);
            neg_q <= bus.sgn && (bus.a[DW-1] ^ bus.b[DW-1]);
            neg_r <= bus.sgn && bus.a[DW-1];
            ovf   <= bus.sgn && (bus.a == {1'b1, {(DW-1){1'b0}}}) && (bus.b == '1);
            if (bus.b == '0) begin
              q_r  <= '1;
              r_r  <= bus.a;
              dz_r <= 1'b1;
              v_r  <= 1'b0;
            end
          end
        end
        BUSY: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            // Sign correction applied to the magnitudes of the final step.
            q_r  <= neg_q ? (~quo_next + 1'b1) : quo_next;
            r_r  <= neg_r ? (~rem_next + 1'b1) : rem_next;
            dz_r <= 1'b0;
            v_r  <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.q         = q_r;
  assign bus.r         = r_r;
  assign bus.dz        = dz_r;
  assign bus.V         = v_r;

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - self-checking bench for div32_seq
module tb_div32_seq;
  import div_pkg::*;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        v;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div32_seq_if bus ();

  div32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t m;
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) begin
      m = '{q: 32'hFFFF_FFFF, r: a, dz: 1'b1, v: 1'b0};
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m = '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0, v: 1'b1};
    end else if (s) begin
      m.q = sa / sbv;
      m.r = sa % sbv;
      m.dz = 1'b0;
      m.v  = 1'b0;
    end else begin
      m.q = a / b;
      m.r = a % b;
      m.dz = 1'b0;
      m.v  = 1'b0;
    end
    return m;
  endfunction

  // Called at a negedge right after the accept edge; counts edges until
  // out_valid and compares the result against the scoreboard head.
  task automatic wait_result(input string tag, input int lat_exp);
    int   lat;
    res_t e;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, lat_exp);
    chk({tag, ".sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".q"}, bus.q, e.q);
      chk({tag, ".r"}, bus.r, e.r);
      chk({tag, ".dz"}, bus.dz, e.dz);
      chk({tag, ".V"}, bus.V, e.v);
    end
    chk({tag, ".in_ready_done"}, bus.in_ready, 0);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_clr"}, bus.out_valid, 0);
    chk({tag, ".in_ready_idle"}, bus.in_ready, 1);
  endtask

  // Starts and ends at a negedge with the divider idle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input res_t exp, input int lat_exp);
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sgn      = s;
    sb.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0;
    bus.sgn      = ~s;
    wait_result(tag, lat_exp);
    release_result(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [31:0] hq, hr;
    logic        seen;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sgn       = 1'b0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    chk("rst.q", bus.q, 0);
    chk("rst.r", bus.r, 0);
    chk("rst.dz", bus.dz, 0);
    chk("rst.V", bus.V, 0);
    chk("rst.out_valid", bus.out_valid, 0);

    // Accept on the very first rising edge with reset released.
    rst_n = 1'b1;
    run_op("unsigned_100_7", 32'd100, 32'd7, 1'b0,
           '{q: 32'd14, r: 32'd2, dz: 1'b0, v: 1'b0}, 33);
    run_op("signed_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1,
           '{q: 32'hFFFF_FFF2, r: 32'hFFFF_FFFE, dz: 1'b0, v: 1'b0}, 33);
    run_op("divzero", 32'h1234_5678, 32'd0, 1'b0,
           '{q: 32'hFFFF_FFFF, r: 32'h1234_5678, dz: 1'b1, v: 1'b0}, 1);
    run_op("divzero_signed", 32'h8765_4321, 32'd0, 1'b1,
           '{q: 32'hFFFF_FFFF, r: 32'h8765_4321, dz: 1'b1, v: 1'b0}, 1);
    run_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
           '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0, v: 1'b1}, 33);
    run_op("unsigned_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0,
           '{q: 32'hFFFF_FFFF, r: 32'd0, dz: 1'b0, v: 1'b0}, 33);
    run_op("unsigned_minusone_as_u", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
           '{q: 32'd0, r: 32'h8000_0000, dz: 1'b0, v: 1'b0}, 33);
    run_op("signed_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
           '{q: 32'hFFFF_FFFD, r: 32'd1, dz: 1'b0, v: 1'b0}, 33);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? ($urandom_range(1, 1000) ^ {32{ra[0]}}) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      rs = i[0];
      run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), 33);
    end

    // Backpressure: hold the result for 10 cycles.
    bus.in_valid = 1'b1;
    bus.a = 32'd1000;
    bus.b = 32'd9;
    bus.sgn = 1'b0;
    sb.push_back('{q: 32'd111, r: 32'd1, dz: 1'b0, v: 1'b0});
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("bp", 33);
    hq = 32'd111;
    hr = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d.out_valid", i), bus.out_valid, 1);
      chk($sformatf("bp.hold%0d.in_ready", i), bus.in_ready, 0);
      chk($sformatf("bp.hold%0d.q", i), bus.q, hq);
      chk($sformatf("bp.hold%0d.r", i), bus.r, hr);
    end
    // New request presented together with out_ready: must not be taken in DONE.
    bus.in_valid  = 1'b1;
    bus.a         = 32'd50;
    bus.b         = 32'd5;
    bus.sgn       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp.leave.out_valid", bus.out_valid, 0);
    chk("bp.leave.in_ready", bus.in_ready, 1);
    sb.push_back('{q: 32'd10, r: 32'd0, dz: 1'b0, v: 1'b0});
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b.accepted", bus.in_ready, 0);
    wait_result("b2b", 33);
    release_result("b2b");

    // Reset in the middle of an operation.
    bus.in_valid = 1'b1;
    bus.a = 32'd123456;
    bus.b = 32'd7;
    bus.sgn = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.q", bus.q, 0);
    chk("midrst.r", bus.r, 0);
    chk("midrst.dz", bus.dz, 0);
    chk("midrst.V", bus.V, 0);
    chk("midrst.out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst.no_result", seen, 0);
    run_op("after_rst_9_3", 32'd9, 32'd3, 1'b0,
           '{q: 32'd3, r: 32'd0, dz: 1'b0, v: 1'b0}, 33);

    chk("sb.empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 Parameters: none; datapath width fixed at 32, iteration count fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  dividend/divisor/sgn valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 a  input  32  dividend.
REQ-007 b  input  32  divisor.
REQ-008 sgn  input  1  1 = two's-complement signed divide, 0 = unsigned.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 q  output  32  quotient.
REQ-012 r  output  32  remainder.
REQ-013 dz  output  1  divide-by-zero flag, qualified by out_valid.
REQ-014 V  output  1  signed overflow flag, qualified by out_valid.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 Accept when in_valid && in_ready at a rising edge; a, b, sgn are captured on that edge and not sampled afterwards.
REQ-017 Accept with b != 0: IDLE -> BUSY, 5-bit iteration counter cleared to 0.
REQ-018 BUSY, per edge: restoring step: shift {rem, quo} left 1; if rem >= |divisor|, subtract and set quo LSB = 1, else restore (LSB = 0); counter += 1.
REQ-019 BUSY with counter == 31: perform the final step and go to DONE; out_valid is first visible exactly 33 edges after the accept edge.
REQ-020 Signed mode: divide magnitudes. Negate q if the operand signs differ. r takes the sign of a. Result is truncation toward zero.
REQ-021 Unsigned mode: operands are used unmodified; V = 0.
REQ-022 b == 0 at accept: IDLE -> DONE on the accept edge; q = 32'hFFFF_FFFF, r = a, dz = 1, V = 0; no iterations.
REQ-023 sgn = 1, a = 32'h8000_0000, b = 32'hFFFF_FFFF: takes the normal BUSY path; result q = 32'h8000_0000, r = 0, V = 1, dz = 0.
REQ-024 DONE: q, r, dz, V hold stable until out_ready; on out_ready, DONE -> IDLE on that edge.
REQ-025 No new accept while DONE, even if out_ready is high the same cycle; the earliest next accept is one edge after leaving DONE.
REQ-026 in_valid during BUSY/DONE is ignored; no queuing.
REQ-027 Outputs are registered; no combinational path from inputs to q, r, dz, V, out_valid.

Reset
REQ-028 rst_n low: state = IDLE, counter = 0, q = 0, r = 0, dz = 0, V = 0, out_valid = 0, in_ready = 1 after release.
REQ-029 Reset asserted mid-BUSY or in DONE aborts the operation immediately; no result is ever presented for it.
REQ-030 The first accept is possible on the first rising edge with rst_n high.

Structure
REQ-031 Shared package div_pkg holds the state enum (IDLE, BUSY, DONE), DW = 32, and CNT_W = 5.
REQ-032 One combinational sub-module, div_step: inputs partial remainder (33 bit), divisor (32 bit); outputs next remainder and quotient bit.
REQ-033 Sign pre-negation and post-correction stay in div32_seq; a single div_step instance is used.

Verification
REQ-034 Unsigned: a = 100, b = 7, sgn = 0 -> after 33 edges, out_valid = 1, q = 14, r = 2, dz = 0, V = 0.
REQ-035 Signed: a = -100 (32'hFFFF_FF9C), b = 7, sgn = 1 -> q = -14 (32'hFFFF_FFF2), r = -2 (32'hFFFF_FFFE).
REQ-036 Divide-by-zero: a = 32'h1234_5678, b = 0 -> out_valid after 1 edge, q = 32'hFFFF_FFFF, r = 32'h1234_5678, dz = 1.
REQ-037 Overflow: sgn = 1, a = 32'h8000_0000, b = 32'hFFFF_FFFF -> q = 32'h8000_0000, r = 0, V = 1.
REQ-038 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> q/r stable, in_ready = 0; raise out_ready -> IDLE next edge, then accept a back-to-back op.
REQ-039 Reset mid-op: assert rst_n low at iteration 16 -> all outputs 0, in_ready = 1 after release; a new op a = 9, b = 3 yields q = 3, r = 0.
